// File: rtl/note_reg_writer.sv
// note_reg_writer: preloads the 4-lane note bitmap from chart memory and scrolls it on each tick.
// Define NOTE_CLEAR_EN to enable per-note clearing through the clr_* ports.
module note_reg_writer #(
    parameter int unsigned DEPTH  = 360,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        start,
    input  logic                        tick,
    input  logic [ADDR_W-1:0]           song_len,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_ack,
    input  logic [LANES-1:0]            mem_data,
    input  logic                        clr_en,
    input  logic [1:0]                  clr_freq,
    input  logic [9:0]                  clr_pos,
    output logic [LANES-1:0][DEPTH-1:0] n_reg,
    output logic                        ready,
    output logic                        song_end,
    output logic                        tick_miss
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, PRELOAD, RUN, FETCH, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  len;
    logic [CNT_W-1:0]   fill_cnt;
    logic [CNT_W-1:0]   drain_cnt;
    logic               pending;
    logic               have_data;
    logic               acked;

    // A handshake only completes while a request is outstanding.
    assign have_data = mem_addr < len;
    assign acked     = mem_req && mem_ack;

`ifdef NOTE_CLEAR_EN
    logic             do_shift;
    logic             clr_hit;
    logic [IDX_W-1:0] clr_idx;
    logic [IDX_W-1:0] clr_idx_m1;

    assign do_shift   = (state == RUN) && (tick || pending);
    assign clr_hit    = clr_en && ((state == RUN) || (state == FETCH)) && (32'(clr_pos) < DEPTH);
    assign clr_idx    = IDX_W'(clr_pos);
    assign clr_idx_m1 = IDX_W'(clr_pos - 10'd1);
`else
    logic unused_clr;
    assign unused_clr = ^{clr_en, clr_freq, clr_pos};
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            n_reg     <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            len       <= '0;
            fill_cnt  <= '0;
            drain_cnt <= '0;
            pending   <= 1'b0;
            ready     <= 1'b0;
            song_end  <= 1'b0;
            tick_miss <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_reg     <= '0;
                        mem_addr  <= '0;
                        fill_cnt  <= '0;
                        drain_cnt <= '0;
                        len       <= song_len;
                        pending   <= 1'b0;
                        ready     <= 1'b0;
                        song_end  <= 1'b0;
                        tick_miss <= 1'b0;
                        state     <= PRELOAD;
                    end
                end
                PRELOAD: begin
                    if (have_data) begin
                        if (acked) begin
                            for (int k = 0; k < LANES; k++)
                                n_reg[k][IDX_W'(fill_cnt)] <= mem_data[k];
                            mem_addr <= mem_addr + ADDR_W'(1);
                            mem_req  <= 1'b0;
                        end else if (!mem_req) begin
                            mem_req <= 1'b1;
                        end
                    end
                    // Past the end of the chart the column stays zero from the start clear.
                    if (acked || !have_data) begin
                        if (fill_cnt == CNT_W'(DEPTH - 1)) begin
                            ready <= 1'b1;
                            state <= RUN;
                        end else begin
                            fill_cnt <= fill_cnt + CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (tick || pending) begin
                        for (int k = 0; k < LANES; k++)
                            n_reg[k] <= {1'b0, n_reg[k][DEPTH-1:1]};
                        pending <= pending && tick;
                        state   <= FETCH;
                        if (!have_data) begin
                            drain_cnt <= drain_cnt + CNT_W'(1);
                            if (drain_cnt == CNT_W'(DEPTH - 1)) begin
                                ready    <= 1'b0;
                                song_end <= 1'b1;
                                state    <= DONE;
                            end
                        end
                    end
                end
                FETCH: begin
                    if (tick) begin
                        if (pending) tick_miss <= 1'b1;
                        else         pending   <= 1'b1;
                    end
                    if (have_data) begin
                        if (acked) begin
                            for (int k = 0; k < LANES; k++)
                                n_reg[k][DEPTH-1] <= mem_data[k];
                            mem_addr <= mem_addr + ADDR_W'(1);
                            mem_req  <= 1'b0;
                            state    <= RUN;
                        end else if (!mem_req) begin
                            mem_req <= 1'b1;
                        end
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef NOTE_CLEAR_EN
            // Placed last so a clear overrides a same-cycle fetch write or shift.
            if (clr_hit) begin
                if (!do_shift)
                    n_reg[clr_freq][clr_idx] <= 1'b0;
                else if (clr_pos != 10'd0)
                    n_reg[clr_freq][clr_idx_m1] <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_note_reg_writer.sv
// Self-checking bench for note_reg_writer: table-driven scenarios plus reset, stall and clear sequences.
module tb_note_reg_writer;
    localparam int unsigned DEPTH  = 360;
    localparam int unsigned LANES  = 4;
    localparam int unsigned ADDR_W = 16;

    typedef logic [LANES-1:0][DEPTH-1:0] map_t;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              start = 1'b0;
    logic              tick = 1'b0;
    logic [ADDR_W-1:0] song_len = '0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [LANES-1:0]  mem_data = '0;
    logic              clr_en = 1'b0;
    logic [1:0]        clr_freq = '0;
    logic [9:0]        clr_pos = '0;
    map_t              n_reg;
    logic              ready;
    logic              song_end;
    logic              tick_miss;

    note_reg_writer #(.DEPTH(DEPTH), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .tick(tick), .song_len(song_len),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .clr_en(clr_en), .clr_freq(clr_freq), .clr_pos(clr_pos), .n_reg(n_reg),
        .ready(ready), .song_end(song_end), .tick_miss(tick_miss)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory responder state: written only by the responder, controlled by the flags below.
    logic mem_en = 1'b1;
    logic inject_ack = 1'b0;
    int   stall = 1;
    int   data_mode = 0;
    int   req_count = 0;

    function automatic logic [3:0] col_val(input logic [ADDR_W-1:0] a);
        if (data_mode == 1) return (a == '0) ? 4'hF : 4'h1;
        return a[3:0];
    endfunction

    initial begin
        int   wait_cnt;
        logic req_prev;
        wait_cnt = 0;
        req_prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (mem_req && !req_prev) req_count++;
            req_prev = mem_req;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (inject_ack) begin
                mem_ack  = 1'b1;
                mem_data = 4'hF;
            end else if (mem_req && mem_en) begin
                if (wait_cnt >= stall) begin
                    mem_ack  = 1'b1;
                    mem_data = col_val(mem_addr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_map(input string name, input map_t exp);
        n_tests++;
        if (n_reg !== exp) begin
            n_fail++;
            for (int k = 0; k < LANES; k++)
                for (int j = 0; j < DEPTH; j++)
                    if (n_reg[k][j] !== exp[k][j]) begin
                        $display("FAIL %s: lane %0d col %0d got %b expected %b",
                                 name, k, j, n_reg[k][j], exp[k][j]);
                        return;
                    end
        end
    endtask

    // Expected bitmap when column j holds chart column (j + off).
    function automatic map_t build_map(input int off);
        map_t m;
        logic [15:0] v;
        for (int j = 0; j < DEPTH; j++) begin
            v = 16'(j + off);
            for (int k = 0; k < LANES; k++) m[k][j] = v[k];
        end
        return m;
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        start = 1'b0;
        tick = 1'b0;
        clr_en = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] len);
        song_len = len;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        n_tests++;
        if (!ready) begin
            n_fail++;
            $display("FAIL %s: ready got 0 expected 1 within 3000 cycles", name);
        end
    endtask

    task automatic wait_addr(input string name, input logic [ADDR_W-1:0] a);
        int n;
        n = 0;
        while (mem_addr !== a && n < 60) begin
            @(negedge Clk);
            n++;
        end
        check(name, 64'(mem_addr), 64'(a));
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge Clk);
        tick = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] len;
        int                mode;
        int                ticks;
        logic              exp_ready;
        logic              exp_end;
        logic [ADDR_W-1:0] exp_addr;
        int                exp_reqs;
        logic [63:0]       exp_lo;    // {lane3..lane0} columns 15..0
        logic [31:0]       exp_hi;    // {lane3..lane0} columns 359..352
        int                full_off;  // -1: no full-bitmap comparison
    } vec_t;

    function automatic vec_t mk(input logic [ADDR_W-1:0] len, input int mode, input int ticks,
                                input logic rdy, input logic fin, input logic [ADDR_W-1:0] addr,
                                input int reqs, input logic [63:0] lo, input logic [31:0] hi,
                                input int off);
        vec_t v;
        v.len = len; v.mode = mode; v.ticks = ticks; v.exp_ready = rdy; v.exp_end = fin;
        v.exp_addr = addr; v.exp_reqs = reqs; v.exp_lo = lo; v.exp_hi = hi; v.full_off = off;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        logic [63:0] act_lo;
        logic [31:0] act_hi;
        int          req_base;
        map_t        exp_map;
        string       tag;

        vecs[0] = mk(16'd400, 0, 0,   1'b1, 1'b0, 16'd360, 360, 64'hFF00_F0F0_CCCC_AAAA, 32'h00F0_CCAA, 0);
        vecs[1] = mk(16'd400, 0, 1,   1'b1, 1'b0, 16'd361, 361, 64'h7F80_7878_6666_5555, 32'h8078_6655, 1);
        vecs[2] = mk(16'd0,   0, 0,   1'b1, 1'b0, 16'd0,   0,   64'h0, 32'h0, -1);
        vecs[3] = mk(16'd0,   0, 360, 1'b0, 1'b1, 16'd0,   0,   64'h0, 32'h0, -1);
        vecs[4] = mk(16'd2,   1, 0,   1'b1, 1'b0, 16'd2,   2,   64'h0001_0001_0001_0003, 32'h0, -1);
        vecs[5] = mk(16'd2,   1, 1,   1'b1, 1'b0, 16'd2,   2,   64'h0000_0000_0000_0001, 32'h0, -1);
        vecs[6] = mk(16'd2,   1, 360, 1'b0, 1'b1, 16'd2,   2,   64'h0, 32'h0, -1);
        vecs[7] = mk(16'd5,   0, 3,   1'b1, 1'b0, 16'd5,   5,   64'h0000_0002_0001_0001, 32'h0, -1);

        // Reset state.
        repeat (2) @(negedge Clk);
        check("rst_n_reg_zero", 64'(n_reg == '0), 64'd1);
        check("rst_outputs", 64'({mem_req, ready, song_end, tick_miss}), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        Reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_reset();
            data_mode = vecs[i].mode;
            stall = 1;
            req_base = req_count;
            do_start(vecs[i].len);
            tag = $sformatf("vec%0d", i);
            wait_ready({tag, "_ready_wait"});
            for (int t = 0; t < vecs[i].ticks; t++) do_tick();
            repeat (6) @(negedge Clk);
            for (int k = 0; k < LANES; k++) begin
                act_lo[k*16 +: 16] = n_reg[k][15:0];
                act_hi[k*8 +: 8]   = n_reg[k][DEPTH-1 -: 8];
            end
            check({tag, "_ready"}, 64'(ready), 64'(vecs[i].exp_ready));
            check({tag, "_song_end"}, 64'(song_end), 64'(vecs[i].exp_end));
            check({tag, "_tick_miss"}, 64'(tick_miss), 64'd0);
            check({tag, "_mem_addr"}, 64'(mem_addr), 64'(vecs[i].exp_addr));
            check({tag, "_req_count"}, 64'(req_count - req_base), 64'(vecs[i].exp_reqs));
            check({tag, "_cols_low"}, act_lo, vecs[i].exp_lo);
            check({tag, "_cols_high"}, 64'(act_hi), 64'(vecs[i].exp_hi));
            if (vecs[i].full_off >= 0) check_map({tag, "_full_map"}, build_map(vecs[i].full_off));
            if (vecs[i].exp_end) check_map({tag, "_drained_zero"}, '0);
        end

        // Reset in the middle of a fetch, then a late ack must be ignored.
        do_reset();
        data_mode = 0;
        stall = 1;
        do_start(16'd400);
        wait_ready("midfetch_ready_wait");
        mem_en = 1'b0;
        tick = 1'b1;
        @(negedge Clk);
        tick = 1'b0;
        repeat (2) @(negedge Clk);
        check("midfetch_req_up", 64'(mem_req), 64'd1);
        Reset_n = 1'b0;
        @(negedge Clk);
        check("midfetch_rst_req", 64'(mem_req), 64'd0);
        check("midfetch_rst_flags", 64'({ready, song_end, tick_miss}), 64'd0);
        check("midfetch_rst_addr", 64'(mem_addr), 64'd0);
        check("midfetch_rst_map", 64'(n_reg == '0), 64'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        inject_ack = 1'b1;
        @(posedge Clk);
        inject_ack = 1'b0;
        repeat (3) @(negedge Clk);
        check("late_ack_map", 64'(n_reg == '0), 64'd1);
        check("late_ack_addr_req", 64'({mem_addr, mem_req}), 64'd0);
        mem_en = 1'b1;

        // Stalled fetch: one tick is held pending, the next is dropped.
        do_reset();
        stall = 1;
        do_start(16'd400);
        wait_ready("stall_ready_wait");
        stall = 10;
        tick = 1'b1; @(negedge Clk); tick = 1'b0; @(negedge Clk);
        tick = 1'b1; @(negedge Clk); tick = 1'b0; @(negedge Clk);
        tick = 1'b1; @(negedge Clk); tick = 1'b0;
        wait_addr("stall_first_fetch", 16'd361);
        @(negedge Clk);
        check("stall_pending_col0", 64'({n_reg[3][0], n_reg[2][0], n_reg[1][0], n_reg[0][0]}), 64'h2);
        check("stall_pending_col358", 64'({n_reg[3][358], n_reg[2][358], n_reg[1][358], n_reg[0][358]}), 64'h8);
        check("stall_pending_col359", 64'({n_reg[3][359], n_reg[2][359], n_reg[1][359], n_reg[0][359]}), 64'h0);
        check("stall_tick_miss", 64'(tick_miss), 64'd1);
        wait_addr("stall_second_fetch", 16'd362);
        repeat (2) @(negedge Clk);
        check_map("stall_full_map", build_map(2));
        check("stall_tick_miss_sticky", 64'(tick_miss), 64'd1);
        stall = 1;

        // Clear request together with a tick.
        do_reset();
        do_start(16'd400);
        wait_ready("clr_ready_wait");
        tick = 1'b1; clr_en = 1'b1; clr_freq = 2'd2; clr_pos = 10'd5;
        @(negedge Clk);
        tick = 1'b0; clr_en = 1'b0;
        repeat (5) @(negedge Clk);
        exp_map = build_map(1);
`ifdef NOTE_CLEAR_EN
        exp_map[2][4] = 1'b0;
        check("clr_lane2_col4", 64'(n_reg[2][4]), 64'd0);
`else
        check("clr_ignored_lane2_col4", 64'(n_reg[2][4]), 64'd1);
`endif
        check_map("clr_full_map", exp_map);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/note_reg_writer.md
Name: note_reg_writer

Overview:
- Producer side of the note register: builds and scrolls the 4-lane x 360-column note bitmap that the note window indexer reads (lane = freq, bit index = time column, column 0 oldest).
- Preloads the first DEPTH columns from chart memory through a req/ack handshake.
- On each scroll tick, shifts every lane toward column 0 and fetches one new column into column DEPTH-1.
- Optionally clears individual notes once they have been hit.

Parameters:
DEPTH, 360, columns per lane (n_reg bit width)
LANES, 4, note lanes; fixed at 4 to match the 2-bit freq select
ADDR_W, 16, chart memory address width

Ports:
Clk  input  1  system clock
Reset_n  input  1  synchronous, active-low reset
start  input  1  begin preload (accepted in IDLE or DONE only)
tick  input  1  one-cycle scroll strobe
song_len  input  ADDR_W  number of chart columns; sampled on accepted start
mem_req  output  1  chart read request
mem_addr  output  ADDR_W  chart column address
mem_ack  input  1  read data valid this cycle
mem_data  input  LANES  column bits, bit k -> lane k
clr_en  input  1  clear-note strobe
clr_freq  input  2  lane to clear
clr_pos  input  10  column to clear
n_reg  output  [LANES-1:0][DEPTH-1:0]  note bitmap
ready  output  1  preload complete, scrolling active
song_end  output  1  chart fully drained
tick_miss  output  1  sticky: a tick was dropped

Behaviour:
- One clock: Clk. Reset is synchronous and active-low (Reset_n). Reset has priority over all other activity.
- Reset values: n_reg=0, mem_req=0, mem_addr=0, ready=0, song_end=0, tick_miss=0, state=IDLE, all counters 0.
- States: IDLE, PRELOAD, RUN, FETCH, DONE.
- IDLE/DONE, start=1 (next edge):
  - n_reg cleared; mem_addr=0; fill_cnt=0; drain_cnt=0; song_len latched.
  - song_end=0, ready=0, tick_miss=0; go to PRELOAD.
  - start in any other state is ignored.
- PRELOAD, mem_addr<len:
  - mem_req=1, with mem_addr stable until mem_ack.
  - On ack: n_reg[k][fill_cnt] <= mem_data[k] for all k; mem_addr++; fill_cnt++; mem_req deasserts the following cycle.
  - New request issued the cycle after that. Minimum 2 cycles per column.
- PRELOAD, mem_addr>=len: no request; write zero column at fill_cnt, one column per cycle.
- PRELOAD exit: after column DEPTH-1 is written, go to RUN and set ready=1. Ticks during PRELOAD are ignored.
- RUN, tick=1:
  - Every lane shifts: bit i <= bit i+1 for i<DEPTH-1; bit DEPTH-1 <= 0.
  - Go to FETCH.
  - If mem_addr>=len: drain_cnt++.
- FETCH, mem_addr<len:
  - Request/ack as in PRELOAD.
  - On ack: bit DEPTH-1 of lane k <= mem_data[k]; mem_addr++; return to RUN.
- FETCH, mem_addr>=len: no request; return to RUN the next cycle.
- Tick while in FETCH: held in a one-deep pending flag, serviced on RUN entry (shift in that cycle).
  - A further tick while the flag is set is dropped and sets tick_miss.
- Drain: when drain_cnt reaches DEPTH, go to DONE and set song_end=1, ready=0. n_reg is all-zero at this point.
- song_len=0: PRELOAD zero-fills in DEPTH cycles, issues no requests, then drains normally.
- mem_addr saturates at song_len and never wraps.
- mem_ack while mem_req=0 is ignored.
- Reset during FETCH/PRELOAD: mem_req=0 after that edge; a late mem_ack is ignored.

Optional Feature:
- Macro: NOTE_CLEAR_EN.
- Defined, active in RUN and FETCH only:
  - clr_en=1 clears n_reg[clr_freq][clr_pos].
  - clr_pos>=DEPTH is ignored.
  - clr_pos refers to pre-shift indices. If a shift occurs the same cycle, bit clr_pos-1 is cleared instead; clr_pos=0 has no effect.
  - If the clear targets the column being written by a fetch in the same cycle, the clear wins.
- Not defined: the clr_* ports exist but are ignored; no clear logic is synthesised.

Test Plan:
- Reset_n=0 for 2 cycles mid-FETCH -> all outputs 0, mem_req=0 next edge, a later mem_ack has no effect.
- song_len=400, memory returns column a as {a[3:0]}, ack 1 cycle after req:
  - ready rises after 360 columns; n_reg[k][j]=j[k] for all j.
  - mem_addr=360.
- After preload, one tick:
  - n_reg[k][j] = previous n_reg[k][j+1].
  - Fetch of addr 360 puts 4'h8 into column 359.
  - mem_addr=361.
- song_len=2, columns 4'hF,4'h1:
  - Exactly 2 requests; bits 0,1 set as given, rest 0.
  - After 360 ticks: song_end=1, n_reg=0.
- Stall mem_ack 10 cycles in FETCH, send 2 ticks -> first pending tick shifts on RUN re-entry; second sets tick_miss=1.
- NOTE_CLEAR_EN: clr_en with freq=2, pos=5, simultaneous with tick -> n_reg[2][4]=0; other lanes unchanged.
